// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 frames.
// Latency: a byte written into an empty FIFO while idle drives tx low on the next edge.
// Backpressure: wr_ready drops while the FIFO is full or rst is high.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int BW  = $clog2(CPB);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CPB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    logic baud_done, fifo_empty, push, pop;

    assign baud_done  = (baud_q == BAUD_MAX);
    assign fifo_empty = (count_q == '0);
    assign wr_ready   = !rst && (count_q != FULL);
    assign push       = wr_valid && wr_ready;
    // The FSM takes a byte either from idle or straight out of a stop bit.
    assign pop        = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_STOP && baud_done));

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign fifo_count = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_q <= ^mem_q[rd_ptr_q];
`endif
            tx_q     <= 1'b0;
            baud_q   <= '0;
            state_q  <= S_START;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                end
                S_START: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=10; a line monitor decodes frames at bit centres.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, tx, busy;
    logic [2:0] fifo_count;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    int vec = 0;
    int errs = 0;
    int cyc = 0;

    uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit          mon_act = 1'b0;
    int          mon_t = 0;
    logic [10:0] mon_bits = '0;
    logic [10:0] frames[$];
    int          starts[$];

    always @(negedge clk) begin
        if (rst) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && tx === 1'b0) begin
                mon_act = 1'b1;
                mon_t = 0;
                mon_bits = '0;
                starts.push_back(cyc);
            end
            if (mon_act) begin
                if (mon_t % 10 == 5) mon_bits[mon_t / 10] = tx;
                if (mon_t == NB * 10 - 5) begin
                    frames.push_back(mon_bits);
                    mon_act = 1'b0;
                end else begin
                    mon_t++;
                end
            end
        end
    end

    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with wr_valid still high.
    task automatic wr_one(input logic [7:0] d, output int acc);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data = d;
        while (wr_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (wr_ready !== 1'b1) begin
            vec++; errs++;
            $display("FAIL wr_timeout byte=%h wr_ready=%b expected 1", d, wr_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec++; if (wr_ready !== 1'b0) begin errs++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
        rst = 1'b0;
        @(negedge clk);
        vec++; if (tx !== 1'b1) begin errs++; $display("FAIL reset_tx got %b exp 1", tx); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
        vec++; if (fifo_count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        vec++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    endtask

    task automatic test_single();
        int acc, n;
        logic [10:0] exp;
        frames.delete(); starts.delete();
        wr_one(8'hA5, acc);
        wr_valid = 1'b0;
        n = 0;
        while (frames.size() < 1 && n < 300) begin @(negedge clk); n++; end
        vec++;
        if (frames.size() < 1) begin
            errs++; $display("FAIL single_timeout frames=%0d exp 1", frames.size());
            return;
        end
        vec++; if (starts[0] !== acc + 1) begin errs++; $display("FAIL single_latency fall=%0d exp %0d", starts[0], acc + 1); end
        exp = frame_of(8'hA5);
        for (int k = 0; k < NB; k++) begin
            vec++;
            if (frames[0][k] !== exp[k]) begin errs++; $display("FAIL single_bit%0d got %b exp %b", k, frames[0][k], exp[k]); end
        end
        n = 0;
        while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        vec++; if (busy !== 1'b0 || cyc - starts[0] !== NB * 10) begin
            errs++; $display("FAIL single_busy_drop after=%0d busy=%b exp %0d busy=0", cyc - starts[0], busy, NB * 10);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[5];
        int acc[5];
        int n;
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        frames.delete(); starts.delete();
        for (int i = 0; i < 5; i++) wr_one(d[i], acc[i]);
        wr_valid = 1'b0;
        vec++; if (acc[4] - acc[0] !== 4) begin errs++; $display("FAIL b2b_accept span=%0d exp 4", acc[4] - acc[0]); end
        n = 0;
        while (frames.size() < 5 && n < 800) begin @(negedge clk); n++; end
        vec++;
        if (frames.size() < 5) begin
            errs++; $display("FAIL b2b_timeout frames=%0d exp 5", frames.size());
            return;
        end
        for (int i = 0; i < 5; i++) begin
            vec++;
            if (frames[i] !== frame_of(d[i])) begin errs++; $display("FAIL b2b_frame%0d got %h exp %h", i, frames[i], frame_of(d[i])); end
        end
        for (int i = 1; i < 5; i++) begin
            vec++;
            if (starts[i] - starts[i-1] !== NB * 10) begin errs++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, starts[i] - starts[i-1], NB * 10); end
        end
        n = 0;
        while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        vec++; if (busy !== 1'b0 || cyc - starts[0] !== 5 * NB * 10) begin
            errs++; $display("FAIL b2b_total got %0d exp %0d", cyc - starts[0], 5 * NB * 10);
        end
    endtask

    task automatic test_fill_stall();
        int acc, n;
        logic [7:0] d[6];
        d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        frames.delete(); starts.delete();
        for (int i = 0; i < 5; i++) wr_one(d[i], acc);
        vec++; if (wr_ready !== 1'b0) begin errs++; $display("FAIL fill_ready got %b exp 0", wr_ready); end
        vec++; if (fifo_count !== 3'd4) begin errs++; $display("FAIL fill_count got %0d exp 4", fifo_count); end
        n = 0;
        while (wr_ready !== 1'b1 && n < 300) begin
            wr_data = (n % 2 == 1) ? 8'hEE : 8'hDD;
            @(negedge clk);
            n++;
        end
        wr_data = 8'h15;
        acc = cyc + 1;
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        while (frames.size() < 6 && n < 900) begin @(negedge clk); n++; end
        vec++;
        if (frames.size() < 6) begin
            errs++; $display("FAIL fill_timeout frames=%0d exp 6", frames.size());
            return;
        end
        vec++; if (acc !== starts[1] + 1) begin errs++; $display("FAIL fill_accept_edge got %0d exp %0d", acc, starts[1] + 1); end
        for (int i = 0; i < 6; i++) begin
            vec++;
            if (frames[i] !== frame_of(d[i])) begin errs++; $display("FAIL fill_frame%0d got %h exp %h", i, frames[i], frame_of(d[i])); end
        end
    endtask

    task automatic test_reset_midframe();
        int acc, n, lows;
        frames.delete(); starts.delete();
        wr_one(8'hFF, acc);
        wr_one(8'h33, acc);
        wr_one(8'h44, acc);
        wr_valid = 1'b0;
        n = 0;
        while (!(mon_act && mon_t >= 43) && n < 300) begin @(negedge clk); n++; end
        vec++; if (!mon_act) begin errs++; $display("FAIL mid_no_frame active=%b exp 1", mon_act); end
        rst = 1'b1;
        #1;
        vec++; if (wr_ready !== 1'b0) begin errs++; $display("FAIL mid_rst_ready got %b exp 0", wr_ready); end
        @(negedge clk);
        rst = 1'b0;
        vec++; if (tx !== 1'b1) begin errs++; $display("FAIL mid_tx got %b exp 1", tx); end
        vec++; if (fifo_count !== 3'd0) begin errs++; $display("FAIL mid_count got %0d exp 0", fifo_count); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy got %b exp 0", busy); end
        frames.delete(); starts.delete();
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        vec++; if (lows !== 0) begin errs++; $display("FAIL mid_quiet low_samples=%0d exp 0", lows); end
        vec++; if (frames.size() !== 0) begin errs++; $display("FAIL mid_frames got %0d exp 0", frames.size()); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int acc, n;
        logic [7:0] d[2];
        logic       p[2];
        d = '{8'h07, 8'h03};
        p = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            frames.delete(); starts.delete();
            wr_one(d[i], acc);
            wr_valid = 1'b0;
            n = 0;
            while (frames.size() < 1 && n < 300) begin @(negedge clk); n++; end
            vec++;
            if (frames.size() < 1) begin
                errs++; $display("FAIL par_timeout byte=%h", d[i]);
                return;
            end
            vec++; if (frames[0][9] !== p[i]) begin errs++; $display("FAIL par_bit byte=%h got %b exp %b", d[i], frames[0][9], p[i]); end
            vec++; if (frames[0] !== frame_of(d[i])) begin errs++; $display("FAIL par_frame got %h exp %h", frames[0], frame_of(d[i])); end
            n = 0;
            while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
            vec++; if (cyc - starts[0] !== 110) begin errs++; $display("FAIL par_len got %0d exp 110", cyc - starts[0]); end
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_fill_stall();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
